// File: rtl/lane_toggle_monitor.sv
// lane_toggle_monitor: per-lane saturating rise/fall edge counters with a request/ack readout port.
// Sticky per-lane overflow flags are built only when LANE_TOGGLE_MONITOR_STICKY_EN is defined.
module lane_toggle_monitor #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             clear,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_ack,
  output logic             rd_ready,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_rise,
  output logic [CNT_W-1:0] rd_fall,
  output logic             rd_err,
  output logic             all_toggled,
  output logic [WIDTH-1:0] ovf
);

  typedef enum logic {RD_IDLE, RD_HOLD} rd_state_t;

  rd_state_t              rd_state;
  logic [WIDTH-1:0]       prev;
  logic                   primed;
  logic [WIDTH-1:0]       rise_vec;
  logic [WIDTH-1:0]       fall_vec;
  logic [WIDTH-1:0]       both_seen;
  logic [WIDTH*CNT_W-1:0] rise_bus;
  logic [WIDTH*CNT_W-1:0] fall_bus;
  logic [CNT_W-1:0]       sel_rise;
  logic [CNT_W-1:0]       sel_fall;
  logic                   sel_err;

  // primed masks the very first sample so the post-reset bus value is not taken as an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      prev   <= din;
      primed <= 1'b1;
    end
  end

  assign rise_vec = ~prev & din & {WIDTH{primed}};
  assign fall_vec = prev & ~din & {WIDTH{primed}};

  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic             rise_seen;
    logic             fall_seen;

    // clear takes priority over an edge arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rise_cnt  <= '0;
        fall_cnt  <= '0;
        rise_seen <= 1'b0;
        fall_seen <= 1'b0;
      end else if (clear) begin
        rise_cnt  <= '0;
        fall_cnt  <= '0;
        rise_seen <= 1'b0;
        fall_seen <= 1'b0;
      end else begin
        if (rise_vec[i]) begin
          rise_seen <= 1'b1;
          if (rise_cnt != '1) rise_cnt <= rise_cnt + CNT_W'(1);
        end
        if (fall_vec[i]) begin
          fall_seen <= 1'b1;
          if (fall_cnt != '1) fall_cnt <= fall_cnt + CNT_W'(1);
        end
      end
    end

    assign rise_bus[i*CNT_W +: CNT_W] = rise_cnt;
    assign fall_bus[i*CNT_W +: CNT_W] = fall_cnt;
    assign both_seen[i]               = rise_seen & fall_seen;

`ifdef LANE_TOGGLE_MONITOR_STICKY_EN
    logic ovf_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf_q <= 1'b0;
      end else if (!clear && ((rise_vec[i] && rise_cnt == '1) ||
                              (fall_vec[i] && fall_cnt == '1))) begin
        ovf_q <= 1'b1;
      end
    end

    assign ovf[i] = ovf_q;
`else
    assign ovf[i] = 1'b0;
`endif
  end

  // out-of-range index reads as zero counts with the error bit set
  always_comb begin
    sel_rise = '0;
    sel_fall = '0;
    sel_err  = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (rd_idx == IDX_W'(i)) begin
        sel_rise = rise_bus[i*CNT_W +: CNT_W];
        sel_fall = fall_bus[i*CNT_W +: CNT_W];
        sel_err  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      all_toggled <= 1'b0;
    end else begin
      all_toggled <= &both_seen;
    end
  end

  // snapshot is taken from the counter registers before this cycle's edge update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_ready <= 1'b1;
      rd_valid <= 1'b0;
      rd_rise  <= '0;
      rd_fall  <= '0;
      rd_err   <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: begin
          if (rd_req) begin
            rd_rise  <= sel_rise;
            rd_fall  <= sel_fall;
            rd_err   <= sel_err;
            rd_valid <= 1'b1;
            rd_ready <= 1'b0;
            rd_state <= RD_HOLD;
          end
        end
        RD_HOLD: begin
          if (rd_ack) begin
            rd_valid <= 1'b0;
            rd_ready <= 1'b1;
            rd_state <= RD_IDLE;
          end
        end
        default: begin
          rd_valid <= 1'b0;
          rd_ready <= 1'b1;
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_toggle_monitor.sv
// tb_lane_toggle_monitor: randomized and directed checks of lane_toggle_monitor against an
// edge-counting reference model; honours LANE_TOGGLE_MONITOR_STICKY_EN for ovf expectations.
module tb_lane_toggle_monitor;
  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int IDX_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
`ifdef LANE_TOGGLE_MONITOR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             clear = 1'b0;
  logic             rd_req = 1'b0;
  logic [IDX_W-1:0] rd_idx = '0;
  logic             rd_ack = 1'b0;
  logic             rd_ready;
  logic             rd_valid;
  logic [CNT_W-1:0] rd_rise;
  logic [CNT_W-1:0] rd_fall;
  logic             rd_err;
  logic             all_toggled;
  logic [WIDTH-1:0] ovf;

  int total = 0;
  int bad = 0;

  lane_toggle_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .clear(clear),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_rise(rd_rise), .rd_fall(rd_fall),
    .rd_err(rd_err), .all_toggled(all_toggled), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Reference model: counts observed transitions per lane as plain integers, capped at CMAX
  int               m_rise [WIDTH];
  int               m_fall [WIDTH];
  bit               m_rseen [WIDTH];
  bit               m_fseen [WIDTH];
  logic [WIDTH-1:0] m_prev;
  bit               m_primed;
  bit               m_all;
  logic [WIDTH-1:0] m_ovf;
  bit               m_tmp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        m_rise[i] = 0; m_fall[i] = 0; m_rseen[i] = 0; m_fseen[i] = 0;
      end
      m_prev = '0; m_primed = 0; m_all = 0; m_ovf = '0;
    end else begin
      m_tmp = 1;
      for (int i = 0; i < WIDTH; i++) m_tmp = m_tmp & m_rseen[i] & m_fseen[i];
      m_all = m_tmp;
      for (int i = 0; i < WIDTH; i++) begin
        if (clear) begin
          m_rise[i] = 0; m_fall[i] = 0; m_rseen[i] = 0; m_fseen[i] = 0;
        end else if (m_primed && m_prev[i] != din[i]) begin
          if (din[i]) begin
            m_rseen[i] = 1;
            if (m_rise[i] == CMAX) m_ovf[i] = m_ovf[i] | STICKY;
            else m_rise[i] = m_rise[i] + 1;
          end else begin
            m_fseen[i] = 1;
            if (m_fall[i] == CMAX) m_ovf[i] = m_ovf[i] | STICKY;
            else m_fall[i] = m_fall[i] + 1;
          end
        end
      end
      m_prev = din;
      m_primed = 1;
    end
  end

  // Pure stimulus: one full request/hold/ack transaction, returning what was observed
  task automatic do_read(input logic [IDX_W-1:0] idx, input logic [WIDTH-1:0] din_req,
                         output logic v, output logic [CNT_W-1:0] r, output logic [CNT_W-1:0] f,
                         output logic e, output logic rdy_hold, output logic idle_ok,
                         output bit timeout);
    int n;
    n = 0;
    timeout = 0;
    while (rd_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (rd_ready !== 1'b1) timeout = 1;
    rd_req = 1'b1; rd_idx = idx; din = din_req;
    @(posedge clk); #1;
    rd_req = 1'b0;
    v = rd_valid; r = rd_rise; f = rd_fall; e = rd_err; rdy_hold = rd_ready;
    rd_ack = 1'b1;
    @(posedge clk); #1;
    rd_ack = 1'b0;
    idle_ok = (rd_ready === 1'b1) && (rd_valid === 1'b0);
  endtask

  logic             v, e, rh, io;
  logic [CNT_W-1:0] r, f;
  bit               to;

  task automatic test_reset;
    rst_n = 1'b0; din = 4'b1010;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    total++;
    if ({rd_ready, rd_valid, rd_rise, rd_fall, rd_err, all_toggled, ovf} !== {1'b1, 1'b0, 8'd0, 8'd0, 1'b0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL reset_values: got rdy=%b vld=%b r=%0d f=%0d err=%b all=%b ovf=%b want 1 0 0 0 0 0 0000",
               rd_ready, rd_valid, rd_rise, rd_fall, rd_err, all_toggled, ovf);
    end
    repeat (3) begin @(posedge clk); #1; end
    for (int i = 0; i < WIDTH; i++) begin
      do_read(IDX_W'(i), din, v, r, f, e, rh, io, to);
      total++;
      if ({to, v, r, f, e, io} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL reset_hold_read lane%0d: got to=%b v=%b r=%0d f=%0d e=%b idle=%b want 0 1 0 0 0 1", i, to, v, r, f, e, io);
      end
    end
    total++;
    if (all_toggled !== 1'b0) begin
      bad++; $display("FAIL reset_all_toggled: got %b want 0", all_toggled);
    end
  endtask

  task automatic test_edges;
    din = 4'b0101;
    @(posedge clk); #1;
    din = 4'b1010;
    @(posedge clk); #1;
    total++;
    if (all_toggled !== 1'b0) begin
      bad++; $display("FAIL edges_all_early: got %b want 0", all_toggled);
    end
    @(posedge clk); #1;
    total++;
    if (all_toggled !== 1'b1) begin
      bad++; $display("FAIL edges_all_late: got %b want 1", all_toggled);
    end
    for (int k = 0; k < 2; k++) begin
      do_read(IDX_W'(k * 3), din, v, r, f, e, rh, io, to);
      total++;
      if ({to, v, r, f, e, rh, io} !== {1'b0, 1'b1, 8'd1, 8'd1, 1'b0, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL edges_read lane%0d: got to=%b v=%b r=%0d f=%0d e=%b rdy=%b idle=%b want 0 1 1 1 0 0 1",
                 k * 3, to, v, r, f, e, rh, io);
      end
    end
  endtask

  task automatic test_saturate;
    logic [WIDTH-1:0] exp_ovf;
    for (int c = 0; c < 600; c++) begin
      din[0] = ~din[0];
      @(posedge clk); #1;
    end
    do_read(IDX_W'(0), din, v, r, f, e, rh, io, to);
    total++;
    if ({to, v, r, f, e} !== {1'b0, 1'b1, 8'd255, 8'd255, 1'b0}) begin
      bad++;
      $display("FAIL saturate_read: got to=%b v=%b r=%0d f=%0d e=%b want 0 1 255 255 0", to, v, r, f, e);
    end
    exp_ovf = STICKY ? 4'b0001 : 4'b0000;
    total++;
    if (ovf !== exp_ovf || m_ovf !== exp_ovf) begin
      bad++; $display("FAIL saturate_ovf: got %b (model %b) want %b", ovf, m_ovf, exp_ovf);
    end
  endtask

  task automatic test_clear_edge;
    logic [WIDTH-1:0] ovf_before;
    ovf_before = ovf;
    din[1] = 1'b0;
    @(posedge clk); #1;
    din[1] = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    @(posedge clk); #1;
    total++;
    if (all_toggled !== 1'b0) begin
      bad++; $display("FAIL clear_all_toggled: got %b want 0", all_toggled);
    end
    do_read(IDX_W'(1), din, v, r, f, e, rh, io, to);
    total++;
    if ({to, v, r, f, e} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
      bad++; $display("FAIL clear_read lane1: got to=%b v=%b r=%0d f=%0d e=%b want 0 1 0 0 0", to, v, r, f, e);
    end
    do_read(IDX_W'(0), din, v, r, f, e, rh, io, to);
    total++;
    if ({to, v, r, f} !== {1'b0, 1'b1, 8'd0, 8'd0}) begin
      bad++; $display("FAIL clear_read lane0: got to=%b v=%b r=%0d f=%0d want 0 1 0 0", to, v, r, f);
    end
    total++;
    if (ovf !== ovf_before) begin
      bad++; $display("FAIL clear_ovf_kept: got %b want %b", ovf, ovf_before);
    end
  endtask

  task automatic test_err_hold;
    rd_req = 1'b1; rd_idx = 3'd5;
    @(posedge clk); #1;
    total++;
    if ({rd_valid, rd_ready, rd_err, rd_rise, rd_fall} !== {1'b1, 1'b0, 1'b1, 8'd0, 8'd0}) begin
      bad++;
      $display("FAIL err_first: got v=%b rdy=%b e=%b r=%0d f=%0d want 1 0 1 0 0", rd_valid, rd_ready, rd_err, rd_rise, rd_fall);
    end
    rd_idx = 3'd0;
    for (int c = 0; c < 4; c++) begin
      din = 4'($urandom);
      @(posedge clk); #1;
      total++;
      if ({rd_valid, rd_ready, rd_err, rd_rise, rd_fall} !== {1'b1, 1'b0, 1'b1, 8'd0, 8'd0}) begin
        bad++;
        $display("FAIL err_hold cyc%0d: got v=%b rdy=%b e=%b r=%0d f=%0d want 1 0 1 0 0", c, rd_valid, rd_ready, rd_err, rd_rise, rd_fall);
      end
    end
    rd_req = 1'b0; rd_ack = 1'b1;
    @(posedge clk); #1;
    total++;
    if ({rd_valid, rd_ready, rd_err} !== {1'b0, 1'b1, 1'b1}) begin
      bad++; $display("FAIL err_ack: got v=%b rdy=%b e=%b want 0 1 1", rd_valid, rd_ready, rd_err);
    end
    repeat (2) begin @(posedge clk); #1; end
    rd_ack = 1'b0;
    total++;
    if ({rd_valid, rd_ready} !== {1'b0, 1'b1}) begin
      bad++; $display("FAIL idle_ack_ignored: got v=%b rdy=%b want 0 1", rd_valid, rd_ready);
    end
  endtask

  task automatic test_reset_hold;
    for (int c = 0; c < 5; c++) begin
      din = ~din;
      @(posedge clk); #1;
    end
    rd_req = 1'b1; rd_idx = 3'd0;
    @(posedge clk); #1;
    rd_req = 1'b0;
    total++;
    if (rd_valid !== 1'b1) begin
      bad++; $display("FAIL rsthold_valid: got %b want 1", rd_valid);
    end
    #2 rst_n = 1'b0; din = 4'b1111;
    #1;
    total++;
    if ({rd_valid, rd_ready, rd_rise, all_toggled, ovf} !== {1'b0, 1'b1, 8'd0, 1'b0, 4'd0}) begin
      bad++;
      $display("FAIL rsthold_async: got v=%b rdy=%b r=%0d all=%b ovf=%b want 0 1 0 0 0000", rd_valid, rd_ready, rd_rise, all_toggled, ovf);
    end
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    for (int i = 0; i < WIDTH; i++) begin
      do_read(IDX_W'(i), din, v, r, f, e, rh, io, to);
      total++;
      if ({to, v, r, f, e} !== {1'b0, 1'b1, 8'd0, 8'd0, 1'b0}) begin
        bad++; $display("FAIL rsthold_read lane%0d: got to=%b v=%b r=%0d f=%0d e=%b want 0 1 0 0 0", i, to, v, r, f, e);
      end
    end
  endtask

  task automatic test_random;
    int               er, ef;
    logic [IDX_W-1:0] idx;
    for (int it = 0; it < 300; it++) begin
      din = 4'($urandom);
      clear = ($urandom_range(0, 15) == 0);
      @(posedge clk); #1;
      clear = 1'b0;
      total++;
      if (all_toggled !== m_all || ovf !== m_ovf) begin
        bad++; $display("FAIL rand_flags it%0d: got all=%b ovf=%b want all=%b ovf=%b", it, all_toggled, ovf, m_all, m_ovf);
      end
      if (it % 20 == 19) begin
        idx = IDX_W'($urandom_range(0, 5));
        er = (idx < WIDTH) ? m_rise[idx] : 0;
        ef = (idx < WIDTH) ? m_fall[idx] : 0;
        do_read(idx, 4'($urandom), v, r, f, e, rh, io, to);
        total++;
        if ({to, v, r, f, e, rh, io} !== {1'b0, 1'b1, CNT_W'(er), CNT_W'(ef), (idx >= WIDTH), 1'b0, 1'b1}) begin
          bad++;
          $display("FAIL rand_read idx%0d: got to=%b v=%b r=%0d f=%0d e=%b rdy=%b idle=%b want 0 1 %0d %0d %b 0 1",
                   idx, to, v, r, f, e, rh, io, er, ef, (idx >= WIDTH));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_edges();
    test_saturate();
    test_clear_edge();
    test_err_hold();
    test_random();
    test_reset_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
